// File: rtl/radar_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radar_sim_pkg
// Description : Shared types and default widths for the radar simulator
//               trigger path (FSM encoding, counter widths, pulse width).
// Revision    : 1.0 - initial release
// ============================================================================
package radar_sim_pkg;

  // Trigger generator FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PULSE = 2'd2
  } trig_state_t;

  localparam int PW_DEF         = 16;
  localparam int CW_DEF         = 16;
  localparam int TRIG_WIDTH_DEF = 8;

endpackage : radar_sim_pkg
`default_nettype wire

// File: rtl/tick_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : tick_sync_edge
// Description : Two-flop synchroniser for an asynchronous divided clock,
//               followed by a rising-edge detector producing a one-cycle
//               tick in the clk domain. Falling edges are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic tick
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchroniser chain plus one extra stage holding the previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign tick = r_s2 & ~r_s3;

endmodule : tick_sync_edge
`default_nettype wire

// File: rtl/radar_trig_gen.sv
`default_nettype none
// ============================================================================
// Module      : radar_trig_gen
// Description : Counts ticks of the divided clock and issues a fixed-width
//               radar trigger every PERIOD ticks, with an azimuth reference
//               pulse every ACP_PER_ARP triggers.
// Options     : RADAR_TRIG_ARP_EN - build the ACP index counter and ARP
//               output; when undefined arp_out is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module radar_trig_gen
  import radar_sim_pkg::*;
#(
  parameter int PW          = PW_DEF,
  parameter int CW          = CW_DEF,
  parameter int TRIG_WIDTH  = TRIG_WIDTH_DEF,
  parameter int ACP_PER_ARP = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick_in,
  input  logic [PW-1:0] period,
  output logic          trig_out,
  output logic          arp_out,
  output logic [CW-1:0] trig_cnt,
  output logic          overrun,
  output logic          busy
);

  localparam int            c_WW         = (TRIG_WIDTH > 1) ? $clog2(TRIG_WIDTH) : 1;
  localparam logic [c_WW-1:0] c_WIDTH_LOAD = c_WW'(TRIG_WIDTH - 1);
  localparam logic [PW-1:0] c_P_ONE      = PW'(1);
  localparam logic [CW-1:0] c_C_ONE      = CW'(1);

  trig_state_t     r_state;
  trig_state_t     w_state_nxt;
  logic            w_tick;
  logic            w_fire;
  logic            w_hold;
  logic            w_width_done;
  logic [PW-1:0]   r_period;
  logic [PW-1:0]   r_tick_cnt;
  logic [c_WW-1:0] r_width_cnt;

  tick_sync_edge u_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (tick_in),
    .tick     (w_tick)
  );

  // A trigger is due on the tick that completes period_r ticks; EN low
  // discards a coincident tick.
  assign w_fire       = en && w_tick && (r_state != ST_IDLE) &&
                        (r_tick_cnt == (r_period - c_P_ONE));
  assign w_hold       = !en || (r_state == ST_IDLE);
  assign w_width_done = (r_width_cnt == '0);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (period != '0) w_state_nxt = ST_COUNT;
        ST_COUNT: if (w_fire) w_state_nxt = ST_PULSE;
        ST_PULSE: begin
          if (w_fire) begin
            w_state_nxt = ST_PULSE;
          end else if (w_width_done) begin
            w_state_nxt = ST_COUNT;
          end
        end
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM output decode
  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  // Tick counter, period latch, pulse width timer, trigger count, overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period    <= '0;
      r_tick_cnt  <= '0;
      r_width_cnt <= '0;
      trig_out    <= 1'b0;
      trig_cnt    <= '0;
      overrun     <= 1'b0;
    end else if (w_hold) begin
      r_tick_cnt  <= '0;
      r_width_cnt <= '0;
      trig_out    <= 1'b0;
      trig_cnt    <= '0;
      overrun     <= 1'b0;
      if (en && (period != '0)) begin
        r_period <= period;
      end
    end else if (w_fire) begin
      r_tick_cnt  <= '0;
      // A zero period seen at a trigger means "every tick"
      r_period    <= (period == '0) ? c_P_ONE : period;
      r_width_cnt <= c_WIDTH_LOAD;
      trig_out    <= 1'b1;
      trig_cnt    <= trig_cnt + c_C_ONE;
      if (r_state == ST_PULSE) begin
        overrun <= 1'b1;
      end
    end else begin
      if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + c_P_ONE;
      end
      if (r_state == ST_PULSE) begin
        if (w_width_done) begin
          trig_out <= 1'b0;
        end else begin
          r_width_cnt <= r_width_cnt - c_WW'(1);
        end
      end
    end
  end

`ifdef RADAR_TRIG_ARP_EN
  localparam int              c_AW       = (ACP_PER_ARP > 1) ? $clog2(ACP_PER_ARP) : 1;
  localparam logic [c_AW-1:0] c_ACP_LAST = c_AW'(ACP_PER_ARP - 1);

  logic [c_AW-1:0] r_acp_idx;

  // ACP index and ARP pulse: ARP marks the trigger at index 0 and lasts as
  // long as that trigger's pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acp_idx <= '0;
      arp_out   <= 1'b0;
    end else if (w_hold) begin
      r_acp_idx <= '0;
      arp_out   <= 1'b0;
    end else if (w_fire) begin
      arp_out   <= (r_acp_idx == '0);
      r_acp_idx <= (r_acp_idx == c_ACP_LAST) ? '0 : r_acp_idx + c_AW'(1);
    end else if ((r_state == ST_PULSE) && w_width_done) begin
      arp_out <= 1'b0;
    end
  end
`else
  localparam int c_unused_acp = ACP_PER_ARP;

  assign arp_out = 1'b0;
`endif

endmodule : radar_trig_gen
`default_nettype wire

// File: tb/tb_radar_trig_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_radar_trig_gen
// Description : Self-checking bench for radar_trig_gen. A cycle-level
//               behavioural model (tick history, tick totals, remaining
//               pulse time) is compared with the DUT on every cycle, and
//               directed phases pin timing with literal expectations.
// Options     : RADAR_TRIG_ARP_EN - selects the expected ARP behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radar_trig_gen;

  localparam int TW  = 3;
  localparam int ACP = 3;
  localparam int PW  = 16;
  localparam int CW  = 16;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          en      = 1'b0;
  logic          tick_in = 1'b0;
  logic [PW-1:0] period  = '0;
  logic          trig_out;
  logic          arp_out;
  logic [CW-1:0] trig_cnt;
  logic          overrun;
  logic          busy;

  radar_trig_gen #(
    .PW          (PW),
    .CW          (CW),
    .TRIG_WIDTH  (TW),
    .ACP_PER_ARP (ACP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tick_in  (tick_in),
    .period   (period),
    .trig_out (trig_out),
    .arp_out  (arp_out),
    .trig_cnt (trig_cnt),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- divided clock generator ----------------
  bit gen_on   = 1'b0;
  int half     = 15;
  int gen_cnt  = 0;
  int tick_rise[$];

  initial forever begin
    @(posedge clk);
    #1;
    if (!gen_on) begin
      gen_cnt = 0;
      tick_in = 1'b0;
    end else begin
      gen_cnt++;
      if (gen_cnt >= half) begin
        gen_cnt = 0;
        tick_in = ~tick_in;
        if (tick_in) tick_rise.push_back(cyc);
      end
    end
  end

  // ---------------- behavioural model ----------------
  bit          m_hist[$];
  bit          m_run   = 1'b0;
  int          m_per   = 0;
  int          m_ticks = 0;
  int          m_hi    = 0;
  logic [CW-1:0] m_cnt = '0;
  bit          m_ovr   = 1'b0;
  int          m_aidx  = 0;
  bit          m_aflag = 1'b0;

  task automatic model_clear();
    m_run = 1'b0; m_ticks = 0; m_hi = 0; m_cnt = '0;
    m_ovr = 1'b0; m_aidx = 0; m_aflag = 1'b0;
  endtask

  task automatic model_step();
    bit t;
    bit fire;
    if (rst) begin
      m_hist.delete();
      repeat (3) m_hist.push_back(1'b0);
      model_clear();
      return;
    end
    // tick_in sampled two edges ago is high, three edges ago was low
    t = m_hist[1] && !m_hist[0];
    m_hist.push_back(tick_in);
    void'(m_hist.pop_front());
    if (!en) begin
      model_clear();
    end else if (!m_run) begin
      if (period != 0) begin
        m_run = 1'b1; m_per = int'(period); m_ticks = 0;
      end
    end else begin
      fire = 1'b0;
      if (t) begin
        m_ticks++;
        if (m_ticks >= m_per) fire = 1'b1;
      end
      if (fire) begin
        if (m_hi > 0) m_ovr = 1'b1;
        m_ticks = 0;
        m_per   = (period == 0) ? 1 : int'(period);
        m_hi    = TW;
        m_cnt   = m_cnt + 1'b1;
        m_aflag = (m_aidx == 0);
        m_aidx  = (m_aidx + 1) % ACP;
      end else if (m_hi > 0) begin
        m_hi--;
      end
    end
  endtask

  initial begin
    m_hist.delete();
    repeat (3) m_hist.push_back(1'b0);
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  task automatic compare_all();
    bit exp_trig;
    bit exp_arp;
    exp_trig = (m_hi > 0);
`ifdef RADAR_TRIG_ARP_EN
    exp_arp = exp_trig && m_aflag;
`else
    exp_arp = 1'b0;
`endif
    chk("trig_out", 32'(trig_out), 32'(exp_trig));
    chk("arp_out",  32'(arp_out),  32'(exp_arp));
    chk("trig_cnt", 32'(trig_cnt), 32'(m_cnt));
    chk("overrun",  32'(overrun),  32'(m_ovr));
    chk("busy",     32'(busy),     32'(m_run));
  endtask

  // ---------------- monitor ----------------
  int rise_cyc[$];
  int rise_cnt[$];
  int rise_arp[$];
  int hi_len[$];
  bit prev_trig = 1'b0;
  int hi_run    = 0;

  initial forever begin
    @(negedge clk);
    compare_all();
    if (rst) begin
      prev_trig = 1'b0;
      hi_run    = 0;
    end else begin
      if (trig_out === 1'b1) begin
        if (!prev_trig) begin
          rise_cyc.push_back(cyc);
          rise_cnt.push_back(int'(trig_cnt));
          rise_arp.push_back(int'(arp_out));
        end
        hi_run++;
      end else if (prev_trig) begin
        hi_len.push_back(hi_run);
        hi_run = 0;
      end
      prev_trig = (trig_out === 1'b1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    rise_cyc.delete(); rise_cnt.delete(); rise_arp.delete();
    hi_len.delete(); tick_rise.delete();
  endtask

  task automatic wait_rises(input string name, input int n, input int budget);
    int k = 0;
    while (rise_cyc.size() < n && k < budget) begin
      step(1);
      k++;
    end
    chk(name, 32'(rise_cyc.size() >= n), 32'd1);
  endtask

  task automatic restart(input int p, input int h);
    en = 1'b0; gen_on = 1'b0;
    step(3);
    clear_q();
    period = PW'(p); half = h; en = 1'b1;
    step(2);
    gen_on = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    step(3);
    chk("rst_trig", 32'(trig_out), 32'd0);
    chk("rst_cnt",  32'(trig_cnt), 32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_ovr",  32'(overrun),  32'd0);
    rst = 1'b0;
    step(2);

    // Basic period: ticks every 30 clk, PERIOD 4, width 3
    restart(4, 15);
    wait_rises("basic_wait", 3, 600);
    step(6);
    chk("basic_lat",    32'(rise_cyc[0] - tick_rise[3]), 32'd3);
    chk("basic_space1", 32'(rise_cyc[1] - rise_cyc[0]),  32'd120);
    chk("basic_space2", 32'(rise_cyc[2] - rise_cyc[1]),  32'd120);
    chk("basic_cnt1",   32'(rise_cnt[0]), 32'd1);
    chk("basic_cnt2",   32'(rise_cnt[1]), 32'd2);
    chk("basic_cnt3",   32'(rise_cnt[2]), 32'd3);
    chk("basic_w1",     32'(hi_len[0]),   32'd3);
    chk("basic_w3",     32'(hi_len[2]),   32'd3);

    // EN drop one clk after a rise
    clear_q();
    wait_rises("endrop_wait", 1, 200);
    en = 1'b0;
    step(1);
    chk("endrop_trig", 32'(trig_out), 32'd0);
    chk("endrop_busy", 32'(busy),     32'd0);
    chk("endrop_cnt",  32'(trig_cnt), 32'd0);

    // Re-enable: first trigger after a full PERIOD
    restart(4, 15);
    wait_rises("reen_wait", 1, 300);
    chk("reen_lat", 32'(rise_cyc[0] - tick_rise[3]), 32'd3);
    chk("reen_cnt", 32'(rise_cnt[0]), 32'd1);

    // PERIOD changed 4 -> 2 mid interval
    restart(4, 15);
    begin
      int k = 0;
      while (tick_rise.size() < 2 && k < 200) begin
        step(1);
        k++;
      end
    end
    period = PW'(2);
    wait_rises("pchg_wait", 3, 600);
    chk("pchg_lat",    32'(rise_cyc[0] - tick_rise[3]), 32'd3);
    chk("pchg_space1", 32'(rise_cyc[1] - rise_cyc[0]),  32'd60);
    chk("pchg_space2", 32'(rise_cyc[2] - rise_cyc[1]),  32'd60);

    // ARP cadence with PERIOD 1
    restart(1, 15);
    wait_rises("arp_wait", 7, 400);
    for (int i = 0; i < 7; i++) begin
`ifdef RADAR_TRIG_ARP_EN
      chk($sformatf("arp_trig%0d", i + 1), 32'(rise_arp[i]), 32'((i % 3) == 0));
`else
      chk($sformatf("arp_trig%0d", i + 1), 32'(rise_arp[i]), 32'd0);
`endif
    end

    // Overrun: ticks every 2 clk, width 3
    restart(1, 1);
    wait_rises("ovr_wait", 1, 50);
    step(12);
    chk("ovr_flag",  32'(overrun),        32'd1);
    chk("ovr_high",  32'(trig_out),       32'd1);
    chk("ovr_solid", 32'(rise_cyc.size()), 32'd1);
    en = 1'b0;
    step(1);
    chk("ovr_clear", 32'(overrun), 32'd0);
    chk("ovr_idle",  32'(busy),    32'd0);

    // PERIOD 0 at enable: nothing ever happens
    restart(0, 3);
    step(1000);
    chk("p0_busy",  32'(busy),             32'd0);
    chk("p0_rises", 32'(rise_cyc.size()),  32'd0);

    // Asynchronous reset during a pulse
    restart(2, 5);
    wait_rises("arst_wait", 1, 100);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_trig", 32'(trig_out), 32'd0);
    chk("arst_cnt",  32'(trig_cnt), 32'd0);
    chk("arst_busy", 32'(busy),     32'd0);
    step(2);
    rst = 1'b0;
    clear_q();
    wait_rises("arst_rewait", 1, 200);
    chk("arst_cnt1", 32'(rise_cnt[0]), 32'd1);

    // Randomised operation against the model
    for (int it = 0; it < 30; it++) begin
      half   = int'($urandom_range(1, 8));
      period = PW'($urandom_range(0, 5));
      en     = ($urandom_range(0, 5) != 0);
      gen_on = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
      step(int'($urandom_range(20, 300)));
    end

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_radar_trig_gen
`default_nettype wire
